pwm8_capture: RTL and testbench

PWM8_CAPTURE -- requirements
Module: pwm8_capture

---
 rtl/pwm8_pkg.sv | 13 +
 rtl/pwm_in_sync.sv | 37 +++
 rtl/pwm8_capture.sv | 113 +++++++++++
 tb/tb_pwm8_capture.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pwm8_pkg.sv
// Shared constants and FSM encoding for the PWM capture block.
package pwm8_pkg;

   localparam int CNT_W_DEF   = 16;
   localparam int TIMEOUT_DEF = 1024;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      MEAS = 2'd2
   } state_t;

endpackage

// File: rtl/pwm_in_sync.sv
// Two-flop synchronizer for the asynchronous PWM pin plus a qualified rise detector.
module pwm_in_sync (
   input  logic clk,
   input  logic rst,
   input  logic pwm_in,
   output logic level,
   output logic rise
);

   logic       sync_1;
   logic       sync_2;
   logic       sync_d;
   logic [1:0] fill;
   logic       low_seen;

   // A rise only counts once the synced level has genuinely been low after reset,
   // so a pin that was already high at reset release is not mistaken for an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_1   <= 1'b0;
         sync_2   <= 1'b0;
         sync_d   <= 1'b0;
         fill     <= 2'd0;
         low_seen <= 1'b0;
      end else begin
         sync_1 <= pwm_in;
         sync_2 <= sync_1;
         sync_d <= sync_2;
         if (fill != 2'd2) fill <= fill + 2'd1;
         if (fill == 2'd2 && !sync_2) low_seen <= 1'b1;
      end
   end

   assign level = sync_2;
   assign rise  = sync_2 & ~sync_d & low_seen;

endmodule

// File: rtl/pwm8_capture.sv
// Measures high time and period of a PWM input, with timeout and valid/ready result handshake.
module pwm8_capture
   import pwm8_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] hi_out,
   output logic [CNT_W-1:0] period_out,
   output logic             stuck,
   output logic             meas_valid,
   input  logic             meas_ready,
   output logic             ovr
);

   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   logic             level;
   logic             rise;
   state_t           state, state_nx;
   logic [CNT_W-1:0] per_cnt, per_nx;
   logic [CNT_W-1:0] hi_cnt, hi_nx;
   logic             pub;
   logic             pub_stuck;

   pwm_in_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .pwm_in (pwm_in),
      .level  (level),
      .rise   (rise)
   );

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nx  = state;
      per_nx    = per_cnt;
      hi_nx     = hi_cnt;
      pub       = 1'b0;
      pub_stuck = 1'b0;
      if (!en) begin
         state_nx = IDLE;
         per_nx   = '0;
         hi_nx    = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nx = ARM;
               per_nx   = '0;
               hi_nx    = '0;
            end
            ARM, MEAS: begin
               if (rise) begin
                  pub      = (state == MEAS);
                  state_nx = MEAS;
                  per_nx   = ONE;
                  hi_nx    = ONE;
               end else if (per_cnt == TO_VAL) begin
                  pub       = 1'b1;
                  pub_stuck = 1'b1;
                  state_nx  = ARM;
                  per_nx    = '0;
                  hi_nx     = '0;
               end else begin
                  per_nx = per_cnt + ONE;
                  if (state == MEAS && level) hi_nx = hi_cnt + ONE;
               end
            end
            default: begin
               state_nx = IDLE;
               per_nx   = '0;
               hi_nx    = '0;
            end
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         per_cnt    <= '0;
         hi_cnt     <= '0;
         hi_out     <= '0;
         period_out <= '0;
         stuck      <= 1'b0;
         meas_valid <= 1'b0;
         ovr        <= 1'b0;
      end else begin
         state   <= state_nx;
         per_cnt <= per_nx;
         hi_cnt  <= hi_nx;
         ovr     <= 1'b0;
         if (!en) begin
            meas_valid <= 1'b0;
         end else if (pub) begin
            stuck      <= pub_stuck;
            period_out <= pub_stuck ? '0 : per_cnt;
            hi_out     <= pub_stuck ? (level ? TO_VAL : '0) : hi_cnt;
            meas_valid <= 1'b1;
            ovr        <= meas_valid & ~meas_ready;
         end else if (meas_valid && meas_ready) begin
            meas_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pwm8_capture.sv
// Directed bench for pwm8_capture: an in-bench 256-cycle PWM source plus forced constant levels.
module tb_pwm8_capture;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        pwm_in;
   logic [15:0] hi_out;
   logic [15:0] period_out;
   logic        stuck;
   logic        meas_valid;
   logic        meas_ready;
   logic        ovr;

   int          n_tests = 0;
   int          n_fail  = 0;

   // PWM source: mode 0 = duty waveform, 1 = held low, 2 = held high.
   int          mode     = 0;
   int          duty     = 64;
   int          duty_req = 64;
   logic [7:0]  pcnt     = 8'd0;

   pwm8_capture dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .pwm_in     (pwm_in),
      .hi_out     (hi_out),
      .period_out (period_out),
      .stuck      (stuck),
      .meas_valid (meas_valid),
      .meas_ready (meas_ready),
      .ovr        (ovr)
   );

   always #5 clk = ~clk;

   initial begin
      pwm_in = 1'b0;
      forever begin
         @(negedge clk);
         if (pcnt == 8'd0) duty = duty_req;
         case (mode)
            1:       pwm_in = 1'b0;
            2:       pwm_in = 1'b1;
            default: pwm_in = (int'(pcnt) < duty);
         endcase
         pcnt = pcnt + 8'd1;
      end
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_result(input string tag, input int limit);
      logic got;
      got = 1'b0;
      for (int i = 0; i < limit && !got; i++) begin
         @(negedge clk);
         if (meas_valid) got = 1'b1;
      end
      if (!got) check({tag, "_timeout"}, 0, 1);
   endtask

   task automatic check_result(input string tag, input int hi, input int per, input int stk);
      check({tag, "_hi"},    hi_out,     hi);
      check({tag, "_per"},   period_out, per);
      check({tag, "_stuck"}, stuck,      stk);
   endtask

   initial begin
      int ovr_cnt;
      int drop_cnt;
      int skips;

      rst        = 1'b1;
      en         = 1'b1;
      meas_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_hi",    hi_out,     0);
      check("rst_per",   period_out, 0);
      check("rst_stuck", stuck,      0);
      check("rst_valid", meas_valid, 0);
      check("rst_ovr",   ovr,        0);
      rst = 1'b0;

      // Duty 64: every result is a full period.
      for (int k = 0; k < 3; k++) begin
         wait_result("d64", 700);
         check_result("d64", 64, 256, 0);
      end

      // Duty 128 then 230, one result skipped at each change.
      duty_req = 128;
      wait_result("d128_skip", 700);
      for (int k = 0; k < 2; k++) begin
         wait_result("d128", 700);
         check_result("d128", 128, 256, 0);
      end
      duty_req = 230;
      wait_result("d230_skip", 700);
      wait_result("d230", 700);
      check_result("d230", 230, 256, 0);

      // Pin held low, then held high.
      mode = 1;
      for (int k = 0; k < 2; k++) begin
         wait_result("low", 1200);
         check_result("low", 0, 0, 1);
      end
      mode = 2;
      for (int k = 0; k < 2; k++) begin
         wait_result("high", 1200);
         check_result("high", 1024, 0, 1);
      end

      // Back to duty 64; discard stuck results left over from the held level.
      duty_req = 64;
      mode     = 0;
      skips    = 0;
      wait_result("resume", 1200);
      while (stuck && skips < 4) begin
         skips++;
         wait_result("resume", 1200);
      end
      check_result("resume", 64, 256, 0);

      // Overrun: consumer stalls across two publishes.
      meas_ready = 1'b0;
      wait_result("ovr_first", 700);
      ovr_cnt  = 0;
      drop_cnt = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (ovr) ovr_cnt++;
         if (!meas_valid) drop_cnt++;
      end
      check("ovr_pulses", ovr_cnt, 1);
      check("ovr_valid_drops", drop_cnt, 0);
      check_result("ovr_held", 64, 256, 0);
      meas_ready = 1'b1;
      @(negedge clk);
      meas_ready = 1'b0;
      check("ovr_accept_valid", meas_valid, 0);
      check("ovr_accept_ovr", ovr, 0);
      meas_ready = 1'b1;

      // Reset in the middle of a period.
      wait_result("pre_rst", 700);
      repeat (100) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_hi",    hi_out,     0);
      check("mid_rst_per",   period_out, 0);
      check("mid_rst_stuck", stuck,      0);
      check("mid_rst_valid", meas_valid, 0);
      check("mid_rst_ovr",   ovr,        0);
      wait_result("post_rst", 700);
      check_result("post_rst", 64, 256, 0);

      // Capture disabled for 100 cycles.
      en       = 1'b0;
      drop_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (meas_valid) drop_cnt++;
      end
      check("en_off_valid_cycles", drop_cnt, 0);
      check("en_off_hi_held", hi_out, 64);
      en = 1'b1;
      wait_result("en_on", 700);
      check_result("en_on", 64, 256, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
